mult_div: RTL
=============

// Module: mult_div
// PURPOSE
//  Multi-cycle MULT/DIV unit of the multicycle MIPS datapath, parallel to the ULA.
//  Consumes the operand-A path (register A / ALUSrcA mux output) and operand B; writes HI/LO.
//  Driven by the control unit with a start/done handshake; control stalls on busy.
//  Results are read later by MFHI/MFLO through the write-back mux.
// PARAMETERS
//  WIDTH   32   operand width; HI/LO are WIDTH each; iteration count = WIDTH
// PORTS
//  clk         in   1      system clock; all state updates on rising edge
//  reset       in   1      synchronous, active-high; one clock, one reset
//  start_mult  in   1      pulse: begin signed multiply of src_a*src_b
//  start_div   in   1      pulse: begin signed divide src_a/src_b
//  src_a       in   WIDTH  operand A (multiplicand / dividend)
//  src_b       in   WIDTH  operand B (multiplier / divisor)
//  busy        out  1      operation in progress; start inputs ignored while 1
//  done        out  1      one-cycle pulse: hi/lo valid (or div-by-zero ended)
//  div_zero    out  1      one-cycle pulse with done: divide by zero, hi/lo unchanged
//  hi          out  WIDTH  HI register (product[63:32] / remainder)
//  lo          out  WIDTH  LO register (product[31:0] / quotient)
//  unsigned_op in   1      (MULT_DIV_UNSIGNED_EN only) 1 = MULTU/DIVU
// BEHAVIOUR
//  - Reset: state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0.
//    Reset mid-operation aborts immediately; no partial result reaches hi/lo.
//  - FSM: IDLE -> MULT (start_mult) | DIV (start_div, src_b!=0) | DZERO (start_div, src_b==0).
//    MULT/DIV -> IDLE after WIDTH iterations; DZERO -> IDLE after one cycle.
//  - start sampled only in IDLE at edge E0; src_a/src_b latched at E0; later operand
//    changes have no effect. start_mult and start_div together: multiply wins.
//  - busy=1 in cycles following E0..E(WIDTH-1); iterations on E1..E(WIDTH).
//    At E(WIDTH): hi/lo written, busy=0, done=1 for exactly one cycle. Latency = WIDTH edges.
//  - Back-to-back: a start in the done cycle is accepted (state already IDLE).
//  - MULT: radix-2 Booth, 2*WIDTH+1 accumulator; {hi,lo} = full signed 2*WIDTH product.
//  - DIV: restoring on magnitudes, signs fixed at end. Quotient truncates toward zero;
//    remainder takes sign of dividend (MIPS semantics). lo=quotient, hi=remainder.
//  - Overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000, no flag.
//  - DZERO: at E1 done=1, div_zero=1 (one cycle), busy=0; hi/lo retain old values.
//  - hi/lo change only at operation completion or reset; stable otherwise.
// CONFIGURATION
//  MULT_DIV_UNSIGNED_EN defined: unsigned_op port exists, latched at E0; when 1, operands
//   are zero-extended, no sign correction (MULTU/DIVU); latency unchanged.
//  Not defined: port absent; all operations signed.
// TESTING
//  1. reset held 2 cycles mid-MULT -> busy=0, done=0, hi=lo=0 next cycle; no later done.
//  2. MULT 7 * -3 -> done 32 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//  3. DIV -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); busy high 32 cycles.
//  4. DIV 5 / 0 with hi=0x11, lo=0x22 -> next cycle done=1, div_zero=1; hi/lo unchanged.
//  5. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; start_mult while busy ignored.
//  6. (MULT_DIV_UNSIGNED_EN) MULTU 0xFFFFFFFF*2 -> hi=0x1, lo=0xFFFFFFFE; DIVU 0xFFFFFFFF/0x10
//     -> lo=0x0FFFFFFF, hi=0xF.

Source files
------------

// File: rtl/mult_div.sv
// mult_div: multi-cycle MULT/DIV unit beside the ULA; writes HI/LO after WIDTH iterations.
// Define MULT_DIV_UNSIGNED_EN to add the unsigned_op port (MULTU/DIVU support).
module mult_div #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_mult,
   input  logic             start_div,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
`ifdef MULT_DIV_UNSIGNED_EN
   input  logic             unsigned_op,
`endif
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, MULT, DIV, DZERO} state_t;

   state_t          state, state_next;
   logic [CW-1:0]   count;
   logic            last_iter;

   logic             start_uns;
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;

   logic [WIDTH:0]   mcand, acc_hi, acc_hi_next;
   logic [WIDTH-1:0] acc_lo, acc_lo_next, prod_hi;
   logic             acc_q, mul_fix;
   logic [WIDTH+1:0] booth_sum;

   logic [WIDTH-1:0] dvs, rem, quo, trial, rem_next, quo_next, quot_final, rem_final;
   logic [WIDTH:0]   shifted;
   logic             fits, neg_q, neg_r;

`ifdef MULT_DIV_UNSIGNED_EN
   assign start_uns = unsigned_op;
`else
   assign start_uns = 1'b0;
`endif

   assign a_neg     = ~start_uns & src_a[WIDTH-1];
   assign b_neg     = ~start_uns & src_b[WIDTH-1];
   assign a_mag     = a_neg ? -src_a : src_a;
   assign b_mag     = b_neg ? -src_b : src_b;
   assign last_iter = (count == CW'(WIDTH-1));
   assign busy      = (state != IDLE);

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start_mult)
               state_next = MULT;
            else if (start_div)
               state_next = (src_b == '0) ? DZERO : DIV;
         end
         MULT, DIV: begin
            if (last_iter)
               state_next = IDLE;
         end
         DZERO:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Booth step: sum is two bits wider than WIDTH so that adding a full-range
   // multiplicand to the upper half cannot overflow before the arithmetic shift.
   // An unsigned multiplier with its MSB set is treated as negative by Booth;
   // mul_fix adds the missing multiplicand*2^WIDTH back in on the final step.
   always_comb begin
      booth_sum = {acc_hi[WIDTH], acc_hi};
      case ({acc_lo[0], acc_q})
         2'b10:   booth_sum = {acc_hi[WIDTH], acc_hi} - {mcand[WIDTH], mcand};
         2'b01:   booth_sum = {acc_hi[WIDTH], acc_hi} + {mcand[WIDTH], mcand};
         default: ;
      endcase
      acc_hi_next = booth_sum[WIDTH+1:1];
      acc_lo_next = {booth_sum[0], acc_lo[WIDTH-1:1]};
      prod_hi     = acc_hi_next[WIDTH-1:0] + (mul_fix ? mcand[WIDTH-1:0] : '0);
   end

   // Restoring division on magnitudes; the partial remainder stays below the
   // divisor, so the trial difference always fits in WIDTH bits when it is kept.
   always_comb begin
      shifted    = {rem, quo[WIDTH-1]};
      trial      = shifted[WIDTH-1:0] - dvs;
      fits       = (shifted >= {1'b0, dvs});
      rem_next   = fits ? trial : shifted[WIDTH-1:0];
      quo_next   = {quo[WIDTH-2:0], fits};
      quot_final = neg_q ? -quo_next : quo_next;
      rem_final  = neg_r ? -rem_next : rem_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         count    <= '0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         mcand    <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         acc_q    <= 1'b0;
         mul_fix  <= 1'b0;
         dvs      <= '0;
         rem      <= '0;
         quo      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
      end else begin
         state    <= state_next;
         done     <= 1'b0;
         div_zero <= 1'b0;
         case (state)
            IDLE: begin
               count <= '0;
               if (start_mult) begin
                  mcand   <= {~start_uns & src_a[WIDTH-1], src_a};
                  acc_hi  <= '0;
                  acc_lo  <= src_b;
                  acc_q   <= 1'b0;
                  mul_fix <= start_uns & src_b[WIDTH-1];
               end else if (start_div) begin
                  dvs   <= b_mag;
                  rem   <= '0;
                  quo   <= a_mag;
                  neg_q <= a_neg ^ b_neg;
                  neg_r <= a_neg;
               end
            end
            MULT: begin
               acc_hi <= acc_hi_next;
               acc_lo <= acc_lo_next;
               acc_q  <= acc_lo[0];
               count  <= count + 1'b1;
               if (last_iter) begin
                  hi   <= prod_hi;
                  lo   <= acc_lo_next;
                  done <= 1'b1;
               end
            end
            DIV: begin
               rem   <= rem_next;
               quo   <= quo_next;
               count <= count + 1'b1;
               if (last_iter) begin
                  hi   <= rem_final;
                  lo   <= quot_final;
                  done <= 1'b1;
               end
            end
            DZERO: begin
               done     <= 1'b1;
               div_zero <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
